// File: rtl/frobenius_norm_sequencer.sv
// frobenius_norm_sequencer: sqrt(sum of squares) of a matrix of doubles using one shared
// multiplier, one shared adder and one square-root unit, with interleaved partial sums.
module frobenius_norm_sequencer #(
    parameter int SIZE_A   = 8,
    parameter int SIZE_B   = 8,
    parameter int LAT_MUL  = 5,
    parameter int LAT_ADD  = 7,
    parameter int LAT_SQRT = 30,
    localparam int N  = SIZE_A * SIZE_B,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [63:0]   mem_rdata,
    output logic [63:0]   mul_dataa,
    output logic [63:0]   mul_datab,
    input  logic [63:0]   mul_result,
    output logic [63:0]   add_dataa,
    output logic [63:0]   add_datab,
    input  logic [63:0]   add_result,
    output logic [63:0]   sqrt_data,
    input  logic [63:0]   sqrt_result,
    output logic          busy,
    output logic [63:0]   val,
    output logic          valid
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = (LAT_ADD > 1) ? $clog2(LAT_ADD) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [CW-1:0] PROD_LAST = CW'(N - 1);
    localparam logic [CW-1:0] LAT_ADD_C = CW'(LAT_ADD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(LAT_ADD - 1);

    generate
        if (LAT_ADD < 1 || N < LAT_ADD) begin : g_bad_params
            $error("frobenius_norm_sequencer: need 1 <= LAT_ADD <= SIZE_A*SIZE_B");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, REDUCE, SQRT_WAIT} state_t;

    state_t                      state_q, state_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic                        rd_q;
    logic [CW-1:0]               prod_q, prod_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [IW-1:0]               red_q, red_d, red_nxt;
    logic                        pend_q, pend_d;
    logic                        busy_q, busy_d;
    logic                        valid_q, valid_d;
    logic [63:0]                 val_q, val_d;
    logic [63:0]                 psum_q [LAT_ADD];
    logic [63:0]                 psum_d [LAT_ADD];
    logic [63:0]                 op_a;
    // Tag pipelines mirror each unit's latency; the MSB marks a result arriving this cycle.
    logic [LAT_MUL-1:0]          mul_v_q, mul_v_d;
    logic [LAT_ADD-1:0]          add_v_q, add_v_d, add_fin_q, add_fin_d;
    logic [LAT_ADD-1:0][IW-1:0]  add_idx_q, add_idx_d;
    logic [LAT_SQRT-1:0]         sqrt_v_q, sqrt_v_d;
    logic                        add_in, add_fin_in, sqrt_in;
    logic [IW-1:0]               add_idx_in;

    assign red_nxt   = red_q + 1'b1;
    assign mul_v_d   = LAT_MUL'({mul_v_q, rd_q});
    assign add_v_d   = LAT_ADD'({add_v_q, add_in});
    assign add_fin_d = LAT_ADD'({add_fin_q, add_fin_in});
    assign add_idx_d = (LAT_ADD * IW)'({add_idx_q, add_idx_in});
    assign sqrt_v_d  = LAT_SQRT'({sqrt_v_q, sqrt_in});
    assign mem_rd_en = (state_q == STREAM);
    assign mem_addr  = addr_q;
    assign mul_dataa = rd_q ? mem_rdata : '0;
    assign mul_datab = rd_q ? mem_rdata : '0;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign val       = val_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        prod_d     = prod_q;
        idx_d      = idx_q;
        red_d      = red_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        val_d      = val_q;
        psum_d     = psum_q;
        op_a       = pend_q ? add_result : psum_q[0];
        add_in     = 1'b0;
        add_fin_in = 1'b0;
        add_idx_in = '0;
        add_dataa  = '0;
        add_datab  = '0;
        sqrt_in    = 1'b0;
        sqrt_data  = '0;
        if (mul_v_q[LAT_MUL-1]) begin
            add_in     = 1'b1;
            add_dataa  = (prod_q < LAT_ADD_C) ? '0 : add_result;
            add_datab  = mul_result;
            add_fin_in = (prod_q == PROD_LAST);
            add_idx_in = idx_q;
            prod_d     = prod_q + 1'b1;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // The last write to each slot is the finished partial sum for that lane.
        if (add_v_q[LAT_ADD-1] && (state_q == STREAM || state_q == DRAIN))
            psum_d[add_idx_q[LAT_ADD-1]] = add_result;
        case (state_q)
            IDLE: if (start && !valid_q) begin
                state_d = STREAM;
                busy_d  = 1'b1;
                prod_d  = '0;
                idx_d   = '0;
                red_d   = '0;
                pend_d  = 1'b0;
            end
            STREAM: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (add_v_q[LAT_ADD-1] && add_fin_q[LAT_ADD-1]) state_d = REDUCE;
            REDUCE: if (!pend_q || add_v_q[LAT_ADD-1]) begin
                if (red_q == IDX_LAST) begin
                    sqrt_in   = 1'b1;
                    sqrt_data = op_a;
                    state_d   = SQRT_WAIT;
                end else begin
                    add_in    = 1'b1;
                    add_dataa = op_a;
                    add_datab = psum_q[red_nxt];
                    red_d     = red_nxt;
                    pend_d    = 1'b1;
                end
            end
            SQRT_WAIT: if (sqrt_v_q[LAT_SQRT-1]) begin
                val_d   = sqrt_result;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            prod_q    <= '0;
            idx_q     <= '0;
            red_q     <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            val_q     <= '0;
            psum_q    <= '{default: '0};
            mul_v_q   <= '0;
            add_v_q   <= '0;
            add_fin_q <= '0;
            add_idx_q <= '0;
            sqrt_v_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_q      <= mem_rd_en;
            prod_q    <= prod_d;
            idx_q     <= idx_d;
            red_q     <= red_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            val_q     <= val_d;
            psum_q    <= psum_d;
            mul_v_q   <= mul_v_d;
            add_v_q   <= add_v_d;
            add_fin_q <= add_fin_d;
            add_idx_q <= add_idx_d;
            sqrt_v_q  <= sqrt_v_d;
        end
    end
endmodule

// File: doc/frobenius_norm_sequencer.md
Name: frobenius_norm_sequencer

Overview:
Time-multiplexed controller that computes the Frobenius norm of a SIZE_A x SIZE_B matrix of IEEE-754 doubles, sqrt(sum of squares), using one shared fp_mult, one shared fp_add and one squareroot_ip.
- It streams elements from a matrix buffer with one-cycle read latency, one element per cycle.
- It interleaves LAT_ADD partial sums to hide adder latency, reduces them serially, then issues the square root.
- It is the area-lean alternative to the fully unrolled norm array, for use by the whitening/ICA normalisation steps.

Parameters:
SIZE_A, 8, matrix rows
SIZE_B, 8, matrix columns (N = SIZE_A*SIZE_B; elaboration error if N < LAT_ADD)
LAT_MUL, 5, fp_mult latency in cycles
LAT_ADD, 7, fp_add latency in cycles (>=1)
LAT_SQRT, 30, squareroot_ip latency in cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin computation; sampled only in IDLE
mem_rd_en  out  1  matrix read strobe
mem_addr  out  clog2(N)  row-major element index (i*SIZE_B+j)
mem_rdata  in  64  element; valid the cycle after mem_rd_en
mul_dataa  out  64  to fp_mult
mul_datab  out  64  to fp_mult
mul_result  in  64  from fp_mult, LAT_MUL after issue
add_dataa  out  64  to fp_add
add_datab  out  64  to fp_add
add_result  in  64  from fp_add, LAT_ADD after issue
sqrt_data  out  64  to squareroot_ip
sqrt_result  in  64  from squareroot_ip, LAT_SQRT after issue
busy  out  1  high from start acceptance until valid
val  out  64  norm result (double)
valid  out  1  one-cycle pulse when val is updated

Behaviour:
- Reset: state=IDLE. mem_rd_en=0, mem_addr=0, busy=0, valid=0, val=0. All in-flight tag shift registers cleared. Results already inside the external units are ignored.
- Unit interfaces have no valid signal. The block tracks each operation with its own LAT_MUL-, LAT_ADD- and LAT_SQRT-deep tag shift registers.
- States: IDLE, STREAM, DRAIN, REDUCE, SQRT_WAIT.
- IDLE: on start=1 go to STREAM and set busy=1. Call the start cycle 0.
- STREAM (cycles 1..N): mem_rd_en=1, mem_addr = 0..N-1. After address N-1 go to DRAIN.
- Multiply: mem_rdata goes to both mul_dataa and mul_datab on the cycle it is valid (cycles 2..N+1).
- Accumulate: product j (j = 0..N-1) arrives at cycle 2+LAT_MUL+j and is issued to fp_add the same cycle:
  - add_datab = product j.
  - add_dataa = +0.0 (64'h0) for j < LAT_ADD, else add_result (the partial sum of product j-LAT_ADD).
  - Partial sum k therefore accumulates products j with j mod LAT_ADD = k.
- DRAIN: capture the final LAT_ADD adder outputs (cycles N+2+LAT_MUL .. N+1+LAT_MUL+LAT_ADD) into psum[0..LAT_ADD-1], indexed by the j mod LAT_ADD of their last product. Then go to REDUCE.
- REDUCE, starting at T0 = N+2+LAT_MUL+LAT_ADD:
  - acc = psum[0].
  - For k = 1..LAT_ADD-1, issue add(acc, psum[k]) at T0+(k-1)*LAT_ADD. acc = result LAT_ADD later.
  - Fixed order; the bench golden model must use the same order, since fp add is not associative.
  - If LAT_ADD=1, REDUCE is skipped and acc = psum[0].
- Square root: sqrt_data = acc, issued at T1 = T0+(LAT_ADD-1)*LAT_ADD; enter SQRT_WAIT.
- SQRT_WAIT: at T1+LAT_SQRT register sqrt_result into val. valid=1 and busy=0 at cycle T1+LAT_SQRT+1, then return to IDLE.
- Default latency from start to valid: 151 cycles.
- val holds its value until the next valid.
- start while busy=1: ignored, no queuing.
- start on the valid cycle: ignored; accepted from the following cycle.
- Unused operand outputs are held at 0 when not issuing (power and debug aid only; the units ignore them).
- reset mid-operation: abort immediately to the reset state. No valid pulse. A subsequent start computes correctly.
- NaN and Inf propagate through the arithmetic unchanged. The block does no exception handling.

Test Plan:
1. Defaults, all 64 elements = 1.0 (64'h3FF0000000000000), start at cycle 0 -> valid at cycle 151, val=8.0 (64'h4020000000000000), busy high cycles 1..150.
2. Element[i][j] = i*8+j as doubles -> val equals the golden model using the same interleaved and reduction order, bit-exact (sum of squares 85344, val ~= 292.137).
3. All zeros -> val=+0.0, valid at cycle 151. Then a single element at index 63 = -3.0, rest 0 -> val=3.0 (64'h4008000000000000).
4. start pulsed again at cycles 10 and 151 during the first run -> only one valid, at cycle 151. A start at cycle 152 produces a second valid 151 cycles later.
5. reset asserted at cycle 100 of a run -> outputs reset next cycle, no valid. Restart with all 2.0 -> val=16.0 (64'h4030000000000000).
6. SIZE_A=2, SIZE_B=4, LAT_ADD=1, LAT_MUL=1, LAT_SQRT=1, elements all 2.0 -> val = sqrt(32) bit-exact, valid at cycle N+2+1+1+0+1+1 = 14.
